// File: rtl/lsu_axi_master_if.sv
// rtl/lsu_axi_master_if.sv - AXI-lite AR/R/AW/W/B channel bundle for the LSU bus master
interface lsu_axi_master_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [ADDR_W-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;

  modport master (
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready,
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready
  );

  modport slave (
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready,
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready
  );
endinterface

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding load/store to AXI-lite master with lane alignment
module lsu_axi_master #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  lsu_axi_master_if.master  bus
);

  typedef enum logic [2:0] {IDLE, AR, R, W, B, RESP} state_t;

  state_t      state;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic        aw_done;
  logic        w_done;
  logic        illegal;
  logic [3:0]  strb;
  logic [31:0] rd_shift;
  logic [31:0] rd_ext;
  logic        aw_fin;
  logic        w_fin;

  assign req_ready = (state == IDLE) && !rst;

  always_comb begin
    illegal = 1'b0;
    case (req_size)
      2'd1:    illegal = req_addr[0];
      2'd2:    illegal = |req_addr[1:0];
      2'd3:    illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  always_comb begin
    strb = 4'b0000;
    case (req_size)
      2'd0:    strb = 4'b0001 << req_addr[1:0];
      2'd1:    strb = 4'b0011 << req_addr[1:0];
      default: strb = 4'b1111;
    endcase
  end

  // Extraction uses the offset/size latched at accept, not the live request.
  always_comb begin
    rd_shift = bus.rdata >> {lat_off, 3'b000};
    rd_ext   = rd_shift;
    case (lat_size)
      2'd0:    rd_ext = lat_unsigned ? {24'd0, rd_shift[7:0]}  : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'd1:    rd_ext = lat_unsigned ? {16'd0, rd_shift[15:0]} : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: rd_ext = rd_shift;
    endcase
  end

  assign aw_fin = aw_done || (bus.awvalid && bus.awready);
  assign w_fin  = w_done  || (bus.wvalid && bus.wready);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      lat_off      <= 2'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
      aw_done      <= 1'b0;
      w_done       <= 1'b0;
      bus.araddr   <= '0;
      bus.arvalid  <= 1'b0;
      bus.rready   <= 1'b0;
      bus.awaddr   <= '0;
      bus.awvalid  <= 1'b0;
      bus.wdata    <= 32'd0;
      bus.wstrb    <= 4'd0;
      bus.wvalid   <= 1'b0;
      bus.bready   <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            lat_off      <= req_addr[1:0];
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            if (illegal) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= 32'd0;
              state      <= RESP;
            end else if (req_wen) begin
              bus.awaddr  <= req_addr;
              bus.awvalid <= 1'b1;
              bus.wdata   <= req_wdata << {req_addr[1:0], 3'b000};
              bus.wstrb   <= strb;
              bus.wvalid  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= W;
            end else begin
              bus.araddr  <= req_addr;
              bus.arvalid <= 1'b1;
              state       <= AR;
            end
          end
        end
        AR: begin
          if (bus.arready) begin
            bus.arvalid <= 1'b0;
            bus.rready  <= 1'b1;
            state       <= R;
          end
        end
        R: begin
          if (bus.rvalid) begin
            bus.rready <= 1'b0;
            resp_rdata <= rd_ext;
            resp_err   <= |bus.rresp;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        W: begin
          if (bus.awvalid && bus.awready) bus.awvalid <= 1'b0;
          if (bus.wvalid && bus.wready)   bus.wvalid  <= 1'b0;
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            bus.bready <= 1'b1;
            state      <= B;
          end
        end
        B: begin
          if (bus.bvalid) begin
            bus.bready <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= |bus.bresp;
            resp_valid <= 1'b1;
            state      <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= 32'd0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - directed bench with reference model, bus slave and per-cycle compare
module tb_lsu_axi_master;
  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_wen, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  lsu_axi_master_if #(.ADDR_W(32)) bus ();

  lsu_axi_master #(.ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .bus(bus.master)
  );

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  // slave configuration
  int          ar_wait, aw_wait, w_wait;
  int          ar_cnt, aw_cnt, w_cnt;
  logic        r_hold;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp, s_bresp;

  // model expectations for the transaction in flight
  logic        mon_en, busy, exp_illegal, exp_err;
  logic [31:0] exp_addr, exp_wdata, exp_rdata;
  logic [3:0]  exp_wstrb;
  int          first_ar, last_aw, last_w, first_b;
  logic [31:0] cap_wdata;
  logic [3:0]  cap_wstrb;

  logic [31:0] g_rdata;
  logic        g_err;
  int          g_lat, g_acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] d, input int off, input int sz, input logic uns);
    logic [31:0] v;
    v = d >> (8 * off);
    if (sz == 0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v - 256;
    end else if (sz == 1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v - 65536;
    end
    return v;
  endfunction

  function automatic logic [3:0] m_strb(input int off, input int sz);
    logic [3:0] s;
    int nb;
    nb = 1 << sz;
    s = 4'b0000;
    for (int i = 0; i < 4; i++)
      if (i >= off && i < off + nb) s[i] = 1'b1;
    return s;
  endfunction

  // bus slave: readies follow valids after a programmable wait
  initial begin
    bus.arready = 0; bus.awready = 0; bus.wready = 0;
    bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
    bus.bvalid = 0; bus.bresp = 0;
    ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
    forever begin
      @(negedge clk);
      if (bus.arvalid) begin bus.arready = (ar_cnt >= ar_wait); ar_cnt++; end
      else begin bus.arready = 0; ar_cnt = 0; end
      if (bus.awvalid) begin bus.awready = (aw_cnt >= aw_wait); aw_cnt++; end
      else begin bus.awready = 0; aw_cnt = 0; end
      if (bus.wvalid) begin bus.wready = (w_cnt >= w_wait); w_cnt++; end
      else begin bus.wready = 0; w_cnt = 0; end
      if (bus.rready && !r_hold) begin bus.rvalid = 1; bus.rdata = s_rdata; bus.rresp = s_rresp; end
      else begin bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; end
      if (bus.bready) begin bus.bvalid = 1; bus.bresp = s_bresp; end
      else begin bus.bvalid = 0; bus.bresp = 0; end
    end
  end

  // compare process: DUT outputs against the model on every meaningful cycle
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (bus.arvalid) begin
        chk("araddr", bus.araddr, exp_addr);
        if (first_ar < 0) first_ar = cyc;
      end
      if (bus.awvalid) begin
        chk("awaddr", bus.awaddr, exp_addr);
        last_aw = cyc;
      end
      if (bus.wvalid) begin
        chk("wdata", bus.wdata, exp_wdata);
        chk("wstrb", {28'd0, bus.wstrb}, {28'd0, exp_wstrb});
        cap_wdata = bus.wdata;
        cap_wstrb = bus.wstrb;
        last_w = cyc;
      end
      if (bus.bready && first_b < 0) first_b = cyc;
      if (exp_illegal) chk("no_bus_on_illegal", {30'd0, bus.arvalid, bus.awvalid}, 32'd0);
      if (resp_valid) begin
        chk("resp_rdata", resp_rdata, exp_rdata);
        chk("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
      end
      if (busy) chk("req_ready_busy", {31'd0, req_ready}, 32'd0);
    end
  end

  task automatic set_model(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                           input int sz, input logic uns);
    int off;
    off = addr % 4;
    exp_addr    = addr;
    exp_illegal = (sz == 3) || ((addr % (1 << sz)) != 0);
    exp_wdata   = wd << (8 * off);
    exp_wstrb   = m_strb(off, sz);
    if (exp_illegal) exp_err = 1'b1;
    else exp_err = wen ? (s_bresp != 0) : (s_rresp != 0);
    exp_rdata   = (exp_illegal || wen) ? 32'd0 : m_load(s_rdata, off, sz, uns);
    first_ar = -1; last_aw = -1; last_w = -1; first_b = -1;
    cap_wdata = 32'hx; cap_wstrb = 4'hx;
  endtask

  task automatic drive_accept(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                              input int sz, input logic uns, output logic ok);
    int n;
    @(negedge clk);
    req_valid = 1; req_wen = wen; req_addr = addr; req_wdata = wd;
    req_size = 2'(sz); req_unsigned = uns;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    ok = req_ready;
    if (!ok) begin
      chk("accept_timeout", {31'd0, req_ready}, 32'd1);
      req_valid = 0;
    end else begin
      g_acc = cyc;
      @(posedge clk);
      #1 req_valid = 0;
      busy = 1;
    end
  endtask

  task automatic issue(input logic wen, input logic [31:0] addr, input logic [31:0] wd,
                       input int sz, input logic uns, input int stall);
    int n;
    logic ok;
    set_model(wen, addr, wd, sz, uns);
    resp_ready = (stall == 0);
    drive_accept(wen, addr, wd, sz, uns, ok);
    if (ok) begin
      @(negedge clk);
      n = 0;
      while (!resp_valid && n < 50) begin @(negedge clk); n++; end
      if (!resp_valid) begin
        chk("resp_timeout", {31'd0, resp_valid}, 32'd1);
        busy = 0;
        g_lat = -1; g_rdata = 32'hx; g_err = 1'bx;
      end else begin
        g_lat = cyc - g_acc;
        g_rdata = resp_rdata;
        g_err = resp_err;
        if (stall > 0) begin
          repeat (stall) @(negedge clk);
          chk("stall_valid_held", {31'd0, resp_valid}, 32'd1);
          chk("stall_rdata_held", resp_rdata, g_rdata);
          resp_ready = 1;
        end
        @(posedge clk);
        #1 busy = 0;
      end
    end
    resp_ready = 1;
    exp_illegal = 0;
  endtask

  initial begin
    logic ok;
    int n;
    rst = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
    req_size = 0; req_unsigned = 0; resp_ready = 1;
    ar_wait = 0; aw_wait = 0; w_wait = 0; r_hold = 0;
    s_rdata = 0; s_rresp = 0; s_bresp = 0;
    mon_en = 0; busy = 0; exp_illegal = 0;
    repeat (3) @(negedge clk);
    chk("rst_valids", {26'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, resp_valid}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_araddr", bus.araddr, 32'd0);
    chk("rst_awaddr", bus.awaddr, 32'd0);
    chk("rst_wdata", bus.wdata, 32'd0);
    chk("rst_wstrb_err_rdata", {27'd0, bus.wstrb, resp_err} | resp_rdata, 32'd0);
    rst = 0;
    @(negedge clk);
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    mon_en = 1;

    // word load, zero-wait
    s_rdata = 32'hDEADBEEF;
    issue(0, 32'h80000004, 0, 2, 0, 0);
    chk("lw_rdata_lit", g_rdata, 32'hDEADBEEF);
    chk("lw_err_lit", {31'd0, g_err}, 32'd0);
    chk("lw_latency", g_lat, 3);
    chk("lw_ar_cycle", first_ar - g_acc, 1);

    // sub-word loads
    s_rdata = 32'h80112233;
    issue(0, 32'h80000003, 0, 0, 0, 0);
    chk("lb_lit", g_rdata, 32'hFFFFFF80);
    issue(0, 32'h80000003, 0, 0, 1, 0);
    chk("lbu_lit", g_rdata, 32'h00000080);
    issue(0, 32'h80000002, 0, 1, 0, 0);
    chk("lh_lit", g_rdata, 32'hFFFF8011);
    issue(0, 32'h80000000, 0, 1, 1, 0);
    chk("lhu_lit", g_rdata, 32'h00002233);
    issue(0, 32'h80000001, 0, 0, 0, 0);
    chk("lb_off1_lit", g_rdata, 32'h00000022);

    // stores, zero-wait
    issue(1, 32'h80000001, 32'h000000AB, 0, 0, 0);
    chk("sb_wdata_lit", cap_wdata, 32'h0000AB00);
    chk("sb_wstrb_lit", {28'd0, cap_wstrb}, 32'h2);
    chk("sb_latency", g_lat, 3);
    chk("sb_rdata_zero", g_rdata, 32'd0);
    issue(1, 32'h80000002, 32'h00001234, 1, 0, 0);
    chk("sh_wdata_lit", cap_wdata, 32'h12340000);
    chk("sh_wstrb_lit", {28'd0, cap_wstrb}, 32'hC);
    issue(1, 32'h80000000, 32'hCAFEF00D, 2, 0, 0);
    chk("sw_wstrb_lit", {28'd0, cap_wstrb}, 32'hF);
    chk("sw_wdata_lit", cap_wdata, 32'hCAFEF00D);

    // wready immediately, awready delayed to cycle 3, error bresp
    aw_wait = 2; s_bresp = 2'b10;
    issue(1, 32'h80000008, 32'h55667788, 2, 0, 0);
    chk("split_w_last", last_w - g_acc, 1);
    chk("split_aw_last", last_aw - g_acc, 3);
    chk("split_bready_first", first_b - g_acc, 4);
    chk("split_err_lit", {31'd0, g_err}, 32'd1);
    chk("split_latency", g_lat, 5);
    aw_wait = 0; s_bresp = 0;

    // load with slave error
    s_rresp = 2'b11;
    issue(0, 32'h80000004, 0, 2, 0, 0);
    chk("rresp_err_lit", {31'd0, g_err}, 32'd1);
    s_rresp = 0;

    // illegal requests
    issue(0, 32'h80000002, 0, 2, 0, 0);
    chk("mis_lw_latency", g_lat, 1);
    chk("mis_lw_err", {31'd0, g_err}, 32'd1);
    chk("mis_lw_rdata", g_rdata, 32'd0);
    chk("mis_lw_no_ar", first_ar, -1);
    issue(1, 32'h80000000, 32'h11111111, 3, 0, 0);
    chk("size3_latency", g_lat, 1);
    chk("size3_no_aw", last_aw, -1);

    // response stall with resp_ready low
    s_rdata = 32'h01020304;
    issue(0, 32'h80000001, 0, 0, 0, 4);
    chk("stall_rdata_lit", g_rdata, 32'h00000003);

    // reset while waiting in R
    r_hold = 1;
    set_model(0, 32'h80000010, 0, 2, 0);
    drive_accept(0, 32'h80000010, 0, 2, 0, ok);
    n = 0;
    while (!bus.rready && n < 20) begin @(negedge clk); n++; end
    chk("rst_test_in_r", {31'd0, bus.rready}, 32'd1);
    busy = 0;
    rst = 1;
    @(negedge clk);
    chk("midrst_outputs", {25'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready, resp_valid, req_ready}, 32'd0);
    rst = 0; r_hold = 0;
    @(negedge clk);
    chk("midrst_req_ready", {31'd0, req_ready}, 32'd1);
    s_rdata = 32'h0BADF00D;
    issue(0, 32'h80000010, 0, 2, 0, 0);
    chk("post_rst_lw_lit", g_rdata, 32'h0BADF00D);
    chk("post_rst_latency", g_lat, 3);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
